// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the instruction-fetch slice of the multi-cycle MIPS
// core:
//   - fetch_state_t : fetch FSM state encoding (FETCH / HOLD / HALT)
//   - DEFAULT_*     : reset PC and legal text-segment window defaults
//   - IMM16_* / TARGET26_* : instruction field positions used by next-PC logic
//   - helper functions for branch offset, jump target and PC legality
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t HOLD  = 2'd1;
    localparam fetch_state_t HALT  = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_TEXT_LIMIT = 32'h0000_4000;

    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    // Branch displacement: sign-extended word offset converted to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump target: keep the region bits of the sequential PC
    // and splice in the 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] target);
        return {region, target, 2'b00};
    endfunction

    // A fetch address must be word aligned and inside [base, limit).
    // Anything that wrapped past zero lands far outside the window and is
    // rejected by the same comparisons.
    function automatic logic pc_is_legal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] limit);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
//
// Combinational next-PC selection for the fetch unit.
//
// Ports:
//   pc_plus4  in  32  sequential successor of the current PC
//   instr     in  32  instruction currently held by fetch
//   npc_sel   in  1   non-sequential control from the decoder
//   j_ctl     in  1   j/jal absolute jump
//   jr_ctl    in  1   jr register jump
//   zero      in  1   ALU equality result (beq taken when set with npc_sel)
//   rs_data   in  32  register rs value for jr
//   next_pc   out 32  selected next PC
//   illegal   out 1   next_pc is misaligned or outside the text window
//
// Priority: jr, then j/jal, then taken beq, otherwise sequential.
// ---------------------------------------------------------------------------
module npc_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = DEFAULT_TEXT_LIMIT
) (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        npc_sel,
    input  logic        j_ctl,
    input  logic        jr_ctl,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        illegal
);

    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic        unused_opcode;

    assign imm16    = instr[IMM16_MSB:IMM16_LSB];
    assign target26 = instr[TARGET26_MSB:TARGET26_LSB];

    // The opcode field is decoded upstream; only the immediate and target
    // fields matter for address generation.
    assign unused_opcode = ^instr[31:TARGET26_MSB+1];

    assign branch_pc = pc_plus4 + branch_offset(imm16);
    assign jump_pc   = jump_target(pc_plus4[31:28], target26);

    // Redirect priority. A beq with zero clear falls through to the
    // sequential PC just like a plain instruction.
    always_comb begin
        next_pc = pc_plus4;
        if (jr_ctl) begin
            next_pc = rs_data;
        end else if (j_ctl) begin
            next_pc = jump_pc;
        end else if (npc_sel && zero) begin
            next_pc = branch_pc;
        end
    end

    assign illegal = !pc_is_legal(next_pc, TEXT_BASE, TEXT_LIMIT);

endmodule

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction-fetch stage of the multi-cycle MIPS core. Holds the PC, issues
// one request at a time to a variable-latency instruction memory and presents
// one instruction at a time to decode with a valid/accept handshake.
//
// Ports:
//   clk          in  1   core clock, rising-edge state updates
//   reset        in  1   synchronous active-high reset
//   imem_req     out 1   fetch request, held until imem_ready
//   imem_addr    out 32  fetch address (equals pc)
//   imem_ready   in  1   one-cycle pulse, imem_rdata valid
//   imem_rdata   in  32  fetched instruction word
//   instr        out 32  registered instruction presented to decode
//   pc           out 32  address of instr
//   pc_plus4     out 32  pc + 4 (jal link value)
//   instr_valid  out 1   instr/pc hold a fetched instruction
//   instr_accept in  1   decode retires instr; redirect inputs valid
//   npc_sel      in  1   non-sequential control
//   j_ctl        in  1   j/jal absolute jump
//   jr_ctl       in  1   jr register jump
//   zero         in  1   ALU equality result for beq
//   rs_data      in  32  register rs value for jr
//   pc_err       out 1   sticky illegal-next-PC flag, fetch halted
//
// FSM: FETCH waits for memory, HOLD waits for decode, HALT is terminal until
// reset.
// ---------------------------------------------------------------------------
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = DEFAULT_TEXT_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        npc_sel,
    input  logic        j_ctl,
    input  logic        jr_ctl,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        pc_err
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         next_illegal;

    assign pc_plus4 = pc + 32'd4;

    // The request is masked during reset so the memory, which shares this
    // reset, never sees a request it is about to discard.
    assign imem_req    = (state == FETCH) && !reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

    npc_calc #(
        .TEXT_BASE  (TEXT_BASE),
        .TEXT_LIMIT (TEXT_LIMIT)
    ) u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .npc_sel  (npc_sel),
        .j_ctl    (j_ctl),
        .jr_ctl   (jr_ctl),
        .zero     (zero),
        .rs_data  (rs_data),
        .next_pc  (next_pc),
        .illegal  (next_illegal)
    );

    // Fetch FSM together with the PC, instruction and error registers.
    // imem_ready is only honoured in FETCH and instr_accept only in HOLD, so
    // stray pulses in other states cannot disturb the held instruction.
    // An illegal redirect leaves pc on the offending instruction for debug.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            instr  <= 32'd0;
            pc_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_accept) begin
                        if (next_illegal) begin
                            pc_err <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Scoreboard bench for mips_fetch_unit. The driver acts as instruction
// memory and decoder; a reference model computes every next fetch address
// from the architectural rules and queues expectations. A negedge monitor
// pops and compares whenever the DUT starts a fetch, presents an
// instruction or raises pc_err.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic        npc_sel = 1'b0;
    logic        j_ctl = 1'b0;
    logic        jr_ctl = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        pc_err;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .npc_sel      (npc_sel),
        .j_ctl        (j_ctl),
        .jr_ctl       (jr_ctl),
        .zero         (zero),
        .rs_data      (rs_data),
        .pc_err       (pc_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } hold_t;

    logic [31:0] fetch_q[$];
    hold_t       hold_q[$];
    logic [31:0] err_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = 32'h3000;
    bit          model_halted = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC: architectural rules in plain arithmetic.
    function automatic logic [31:0] refNextPc(input logic [31:0] cur_pc,
                                              input logic [31:0] word,
                                              input bit sel, input bit j,
                                              input bit jr, input bit z,
                                              input logic [31:0] rs);
        logic [31:0] seq;
        int          disp;
        seq = cur_pc + 32'd4;
        if (jr) return rs;
        if (j) return (seq & 32'hF000_0000) + (word & 32'h03FF_FFFF) * 4;
        if (sel && z) begin
            disp = int'($signed(word[15:0]));
            return seq + 32'(disp * 4);
        end
        return seq;
    endfunction

    function automatic bit refLegal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a < 32'h4000);
    endfunction

    // One full instruction: wait for request, answer after rdy_dly cycles,
    // stall decode for 'stall' cycles with garbage and stray ready pulses,
    // then accept with the given redirect inputs.
    task automatic applyStimulus(input int rdy_dly, input logic [31:0] word,
                                 input int stall, input bit sel, input bit j,
                                 input bit jr, input bit z,
                                 input logic [31:0] rs);
        int          n;
        logic [31:0] nxt;
        if (model_halted) return;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checkOutput("req_timeout", 32'd0, 32'd1);
            model_halted = 1'b1;
            return;
        end
        repeat (rdy_dly) @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = word;
        hold_q.push_back('{pc: model_pc, word: word});
        @(negedge clk);
        imem_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            imem_ready = (k % 2 == 0);
            imem_rdata = $urandom();
            npc_sel    = 1'($urandom_range(0, 1));
            j_ctl      = 1'($urandom_range(0, 1));
            jr_ctl     = 1'($urandom_range(0, 1));
            zero       = 1'($urandom_range(0, 1));
            rs_data    = $urandom();
            @(negedge clk);
        end
        imem_ready   = 1'b0;
        instr_accept = 1'b1;
        npc_sel      = sel;
        j_ctl        = j;
        jr_ctl       = jr;
        zero         = z;
        rs_data      = rs;
        nxt = refNextPc(model_pc, word, sel, j, jr, z, rs);
        if (refLegal(nxt)) begin
            model_pc = nxt;
            fetch_q.push_back(nxt);
        end else begin
            err_q.push_back(model_pc);
            model_halted = 1'b1;
        end
        @(negedge clk);
        instr_accept = 1'b0;
        npc_sel      = 1'b0;
        j_ctl        = 1'b0;
        jr_ctl       = 1'b0;
        zero         = 1'b0;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        checkOutput("queues_drained", 32'(fetch_q.size() + hold_q.size() + err_q.size()), 32'd0);
        fetch_q.delete();
        hold_q.delete();
        err_q.delete();
        reset        = 1'b1;
        imem_ready   = 1'b0;
        instr_accept = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_pc", pc, 32'h3000);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc_err", 32'(pc_err), 32'd0);
        model_pc     = 32'h3000;
        model_halted = 1'b0;
        fetch_q.push_back(32'h3000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops an expectation at each new fetch, new presented
    // instruction or new error, and checks held values every cycle.
    logic [31:0] cur_fetch = 32'd0;
    logic [31:0] halt_pc = 32'd0;
    hold_t       cur_hold = '{pc: 32'd0, word: 32'd0};
    bit          prev_req = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_err = 1'b0;
    bit          halted = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            prev_err   = 1'b0;
            halted     = 1'b0;
        end else begin
            checkOutput("req_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
            if (imem_req && !prev_req) begin
                if (fetch_q.size() == 0) begin
                    checkOutput("unexpected_fetch", 32'd1, 32'd0);
                    cur_fetch = 32'hFFFF_FFFF;
                end else begin
                    cur_fetch = fetch_q.pop_front();
                end
            end
            if (imem_req) checkOutput("imem_addr", imem_addr, cur_fetch);
            if (instr_valid && !prev_valid) begin
                if (hold_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                    cur_hold = '{pc: 32'hFFFF_FFFF, word: 32'hFFFF_FFFF};
                end else begin
                    cur_hold = hold_q.pop_front();
                end
            end
            if (instr_valid) begin
                checkOutput("instr", instr, cur_hold.word);
                checkOutput("pc", pc, cur_hold.pc);
                checkOutput("pc_plus4", pc_plus4, cur_hold.pc + 32'd4);
            end
            if (pc_err && !prev_err) begin
                if (err_q.size() == 0) begin
                    checkOutput("unexpected_pc_err", 32'd1, 32'd0);
                    halt_pc = 32'hFFFF_FFFF;
                end else begin
                    halt_pc = err_q.pop_front();
                end
                halted = 1'b1;
            end
            if (halted) begin
                checkOutput("halt_imem_req", 32'(imem_req), 32'd0);
                checkOutput("halt_instr_valid", 32'(instr_valid), 32'd0);
                checkOutput("halt_pc", pc, halt_pc);
                checkOutput("halt_pc_err", 32'(pc_err), 32'd1);
            end
            prev_req   = imem_req;
            prev_valid = instr_valid;
            prev_err   = pc_err;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          kind;
        int          rdy;
        int          st;
        logic [31:0] word;
        logic [31:0] rs;
        bit          sel;
        bit          j;
        bit          jr;
        bit          z;

        resetDut();

        // Directed walk: sequential, beq taken/not taken, j, jr with stall.
        applyStimulus(3, 32'h3C010001, 0, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 32'h1000FFFF, 0, 1, 0, 0, 1, 32'd0);
        applyStimulus(1, 32'h1000FFFF, 0, 1, 0, 0, 0, 32'd0);
        applyStimulus(0, 32'h08000C03, 0, 1, 1, 0, 0, 32'd0);
        applyStimulus(2, 32'h00200008, 5, 1, 0, 1, 0, 32'h0000_3010);
        applyStimulus(0, 32'h00200008, 1, 1, 0, 1, 0, 32'h0000_3012);
        repeat (8) @(negedge clk);
        resetDut();

        applyStimulus(0, 32'h00200008, 0, 1, 0, 1, 0, 32'h0000_4000);
        repeat (4) @(negedge clk);
        resetDut();

        // Window edges: base inclusive, last word legal, limit illegal.
        applyStimulus(0, 32'h00200008, 0, 1, 0, 1, 0, 32'h0000_3000);
        applyStimulus(0, 32'h08000FFF, 0, 1, 1, 0, 0, 32'd0);
        applyStimulus(0, 32'h3C020002, 0, 0, 0, 0, 0, 32'd0);
        repeat (4) @(negedge clk);
        resetDut();

        applyStimulus(1, 32'h1000FFFE, 0, 1, 0, 0, 1, 32'd0);
        repeat (4) @(negedge clk);
        resetDut();

        // Priority: jr beats j beats beq; large negative branch wraps.
        applyStimulus(0, 32'h08000FFF, 0, 1, 1, 1, 1, 32'h0000_3020);
        applyStimulus(0, 32'h08000C10, 0, 1, 1, 0, 1, 32'h0000_3080);
        applyStimulus(0, 32'h10008000, 2, 1, 0, 0, 1, 32'd0);
        repeat (4) @(negedge clk);
        resetDut();

        for (int t = 0; t < 400; t++) begin
            if (model_halted) begin
                repeat (4) @(negedge clk);
                resetDut();
            end
            kind = $urandom_range(0, 19);
            rdy  = $urandom_range(0, 3);
            st   = $urandom_range(0, 3);
            word = $urandom();
            rs   = $urandom();
            sel  = 1'b0;
            j    = 1'b0;
            jr   = 1'b0;
            z    = 1'($urandom_range(0, 1));
            if (kind < 8) begin
                sel = 1'b0;
            end else if (kind < 13) begin
                sel = 1'b1;
                word[15:0] = 16'(int'($urandom_range(0, 12)) - 6);
            end else if (kind < 16) begin
                sel = 1'b1;
                j   = 1'b1;
                jr  = ($urandom_range(0, 7) == 0);
                word[25:0] = 26'($urandom_range(32'h3000, 32'h3FFC) >> 2);
                rs  = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
            end else begin
                sel = 1'b1;
                jr  = 1'b1;
                j   = 1'($urandom_range(0, 1));
                rs  = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
                if ($urandom_range(0, 9) == 0) rs = rs + 32'd2;
            end
            applyStimulus(rdy, word, st, sel, j, jr, z, rs);
        end

        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("final_queues_drained", 32'(fetch_q.size() + hold_q.size() + err_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
